// File: rtl/jesd207_pkg.sv
// Shared definitions for the JESD207 burst sequencer: FSM state encoding,
// direction constants, default parameter values and the phase-timer load helper.
package jesd207_pkg;

  // Burst sequencer states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_ACTIVE = 3'd2,
    ST_HOLD   = 3'd3,
    ST_GUARD  = 3'd4
  } burst_state_t;

  // Interface direction encoding as seen on tx_nrx / btn_tx_nrx
  localparam logic DIR_TX = 1'b1;
  localparam logic DIR_RX = 1'b0;

  // Default parameter values
  localparam int BURST_LEN_DEF = 64;
  localparam int SETUP_CYC_DEF = 4;
  localparam int HOLD_CYC_DEF  = 4;
  localparam int GUARD_CYC_DEF = 8;

  // Phase lengths are at most 255 cycles, so an 8-bit timer covers them
  localparam int PHASE_WID = 8;

  // The timer reaches zero after load_val further cycles, so a phase of
  // cyc cycles is loaded with cyc-1. A zero-length phase loads 0.
  function automatic logic [PHASE_WID-1:0] phase_load(input int cyc);
    if (cyc > 0) begin
      return PHASE_WID'(cyc - 1);
    end
    return '0;
  endfunction

endpackage

// File: rtl/jesd207_phase_timer.sv
// Loadable down-counter shared by the SETUP, HOLD and GUARD phases.
// The count stops at zero; 'zero' tells the FSM the current phase is over.
module jesd207_phase_timer
  import jesd207_pkg::*;
#(
  parameter int WID = PHASE_WID
) (
  input  logic           mclk,
  input  logic           rstn,
  input  logic           load,
  input  logic [WID-1:0] load_val,
  output logic           zero
);

  logic [WID-1:0] count_reg;

  // Load on request, otherwise count down and park at zero
  always_ff @(posedge mclk or negedge rstn) begin
    if (!rstn) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (count_reg != '0) begin
      count_reg <= count_reg - WID'(1);
    end
  end

  assign zero = (count_reg == '0);

endmodule

// File: rtl/jesd207_burst_ctrl.sv
// Burst sequencer for the JESD207 FIFO datapath. A rising edge on proc_start
// launches one burst: tx_nrx set-up, jesd_en window with per-sample FIFO
// metering, tx_nrx hold, then an idle guard before the next start is taken.
module jesd207_burst_ctrl
  import jesd207_pkg::*;
#(
  parameter int BURST_LEN = BURST_LEN_DEF,
  parameter int CNT_WID   = $clog2(BURST_LEN + 1),
  parameter int SETUP_CYC = SETUP_CYC_DEF,
  parameter int HOLD_CYC  = HOLD_CYC_DEF,
  parameter int GUARD_CYC = GUARD_CYC_DEF
) (
  input  logic               mclk,
  input  logic               rstn,
  input  logic               proc_start,
  input  logic               btn_tx_nrx,
  input  logic               fifo_rempty,
  input  logic               fifo_prog_full,
  input  logic               fifo_wfull,
  output logic               tx_nrx,
  output logic               jesd_en,
  output logic               fifo_rd_en,
  output logic               fifo_wr_en,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [CNT_WID-1:0] sample_cnt
);

  localparam logic [CNT_WID-1:0]   FULL_CNT   = CNT_WID'(BURST_LEN);
  localparam logic [CNT_WID-1:0]   LAST_CNT   = CNT_WID'(BURST_LEN - 1);
  localparam logic [PHASE_WID-1:0] SETUP_LOAD = phase_load(SETUP_CYC);
  localparam logic [PHASE_WID-1:0] HOLD_LOAD  = phase_load(HOLD_CYC);
  localparam logic [PHASE_WID-1:0] GUARD_LOAD = phase_load(GUARD_CYC);
  localparam logic                 HAS_GUARD  = (GUARD_CYC > 0);

  burst_state_t         state_reg;
  burst_state_t         state_next;
  logic                 start_prev_reg;
  logic                 tx_nrx_reg;
  logic                 err_reg;
  logic                 done_reg;
  logic                 done_next;
  logic [CNT_WID-1:0]   sample_cnt_reg;

  logic                 start_edge;
  logic                 in_active;
  logic                 dir_is_tx;
  logic                 dir_is_rx;
  logic                 at_last;
  logic                 rd_en;
  logic                 wr_en;
  logic                 xfer;
  logic                 underrun;
  logic                 overflow;
  logic                 clean_stop;
  logic                 active_end;
  logic                 accept_start;

  logic                 timer_load;
  logic [PHASE_WID-1:0] timer_val;
  logic                 timer_zero;

  jesd207_phase_timer #(
    .WID (PHASE_WID)
  ) u_phase_timer (
    .mclk     (mclk),
    .rstn     (rstn),
    .load     (timer_load),
    .load_val (timer_val),
    .zero     (timer_zero)
  );

  assign start_edge   = proc_start & ~start_prev_reg;
  assign accept_start = (state_reg == ST_IDLE) & start_edge;
  assign in_active    = (state_reg == ST_ACTIVE);
  assign dir_is_tx    = (tx_nrx_reg == DIR_TX);
  assign dir_is_rx    = (tx_nrx_reg == DIR_RX);
  assign at_last      = (sample_cnt_reg == LAST_CNT);

  // TX pops whenever data is present. RX pushes while there is room; the
  // prog-full stop still lets the burst-completing write through so that
  // reaching the count takes precedence over a clean early stop.
  assign rd_en = in_active & dir_is_tx & ~fifo_rempty;
  assign wr_en = in_active & dir_is_rx & ~fifo_wfull & (~fifo_prog_full | at_last);
  assign xfer  = rd_en | wr_en;

  // Burst terminating conditions, evaluated every ACTIVE cycle
  assign underrun   = in_active & dir_is_tx & fifo_rempty;
  assign overflow   = in_active & dir_is_rx & fifo_wfull;
  assign clean_stop = in_active & dir_is_rx & fifo_prog_full & ~fifo_wfull & ~at_last;
  assign active_end = (xfer & at_last) | underrun | overflow | clean_stop;

  // Next-state, phase-timer loading and end-of-burst pulse generation
  always_comb begin
    state_next = state_reg;
    timer_load = 1'b0;
    timer_val  = '0;
    done_next  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (start_edge) begin
          state_next = ST_SETUP;
          timer_load = 1'b1;
          timer_val  = SETUP_LOAD;
        end
      end
      ST_SETUP: begin
        if (timer_zero) begin
          state_next = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        if (active_end) begin
          state_next = ST_HOLD;
          timer_load = 1'b1;
          timer_val  = HOLD_LOAD;
        end
      end
      ST_HOLD: begin
        if (timer_zero) begin
          if (HAS_GUARD) begin
            state_next = ST_GUARD;
            timer_load = 1'b1;
            timer_val  = GUARD_LOAD;
          end else begin
            state_next = ST_IDLE;
            done_next  = 1'b1;
          end
        end
      end
      ST_GUARD: begin
        if (timer_zero) begin
          state_next = ST_IDLE;
          done_next  = 1'b1;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge mclk or negedge rstn) begin
    if (!rstn) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Previous proc_start level for rising-edge detection
  always_ff @(posedge mclk or negedge rstn) begin
    if (!rstn) begin
      start_prev_reg <= 1'b0;
    end else begin
      start_prev_reg <= proc_start;
    end
  end

  // Direction: latched on an accepted start, held through HOLD, dropped for GUARD
  always_ff @(posedge mclk or negedge rstn) begin
    if (!rstn) begin
      tx_nrx_reg <= 1'b0;
    end else if (accept_start) begin
      tx_nrx_reg <= btn_tx_nrx;
    end else if ((state_reg == ST_HOLD) && timer_zero) begin
      tx_nrx_reg <= 1'b0;
    end
  end

  // Sticky underrun/overflow flag, cleared only by the next accepted start
  always_ff @(posedge mclk or negedge rstn) begin
    if (!rstn) begin
      err_reg <= 1'b0;
    end else if (accept_start) begin
      err_reg <= 1'b0;
    end else if (underrun | overflow) begin
      err_reg <= 1'b1;
    end
  end

  // Sample counter: cleared at start, saturating, frozen outside ACTIVE
  always_ff @(posedge mclk or negedge rstn) begin
    if (!rstn) begin
      sample_cnt_reg <= '0;
    end else if (accept_start) begin
      sample_cnt_reg <= '0;
    end else if (xfer && (sample_cnt_reg != FULL_CNT)) begin
      sample_cnt_reg <= sample_cnt_reg + CNT_WID'(1);
    end
  end

  // One-cycle completion pulse on the return to IDLE
  always_ff @(posedge mclk or negedge rstn) begin
    if (!rstn) begin
      done_reg <= 1'b0;
    end else begin
      done_reg <= done_next;
    end
  end

  assign tx_nrx     = tx_nrx_reg;
  assign jesd_en    = in_active;
  assign fifo_rd_en = rd_en;
  assign fifo_wr_en = wr_en;
  assign busy       = (state_reg != ST_IDLE);
  assign done       = done_reg;
  assign err        = err_reg;
  assign sample_cnt = sample_cnt_reg;

endmodule

// File: tb/tb_jesd207_burst_ctrl.sv
// Scoreboard bench for jesd207_burst_ctrl: bursts are issued against a simple
// FIFO environment, the expected outcome of each is derived from the burst
// rules and queued, and a monitor checks every burst as the DUT runs it.
module tb_jesd207_burst_ctrl;

  localparam int L     = 64;
  localparam int SETUP = 4;
  localparam int HOLD  = 4;
  localparam int GUARD = 8;
  localparam int CW    = $clog2(L + 1);
  localparam int NEVER = 100000;

  typedef struct {
    logic dir;
    int   n;
    logic err;
    int   n_act;
    int   start;
  } exp_t;

  logic          mclk = 1'b0;
  logic          rstn;
  logic          proc_start;
  logic          btn_tx_nrx;
  logic          fifo_rempty;
  logic          fifo_prog_full;
  logic          fifo_wfull;
  logic          tx_nrx;
  logic          jesd_en;
  logic          fifo_rd_en;
  logic          fifo_wr_en;
  logic          busy;
  logic          done;
  logic          err;
  logic [CW-1:0] sample_cnt;

  // Second instance: single-sample burst with no guard phase
  logic          s_start;
  logic          s_tx, s_jesd, s_rd, s_wr, s_busy, s_done, s_err;
  logic [0:0]    s_cnt;

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  exp_t sb_q[$];

  // FIFO environment state
  int   tx_avail   = 0;
  int   rx_written = 0;
  int   pf_at      = NEVER;
  int   wf_at      = NEVER;

  assign fifo_rempty    = (tx_avail == 0);
  assign fifo_prog_full = (rx_written >= pf_at);
  assign fifo_wfull     = (rx_written >= wf_at);

  always #5 mclk = ~mclk;
  always @(posedge mclk) cyc <= cyc + 1;

  jesd207_burst_ctrl #(
    .BURST_LEN (L), .SETUP_CYC (SETUP), .HOLD_CYC (HOLD), .GUARD_CYC (GUARD)
  ) dut (
    .mclk (mclk), .rstn (rstn), .proc_start (proc_start), .btn_tx_nrx (btn_tx_nrx),
    .fifo_rempty (fifo_rempty), .fifo_prog_full (fifo_prog_full), .fifo_wfull (fifo_wfull),
    .tx_nrx (tx_nrx), .jesd_en (jesd_en), .fifo_rd_en (fifo_rd_en), .fifo_wr_en (fifo_wr_en),
    .busy (busy), .done (done), .err (err), .sample_cnt (sample_cnt)
  );

  jesd207_burst_ctrl #(
    .BURST_LEN (1), .SETUP_CYC (4), .HOLD_CYC (4), .GUARD_CYC (0)
  ) dut_s (
    .mclk (mclk), .rstn (rstn), .proc_start (s_start), .btn_tx_nrx (1'b1),
    .fifo_rempty (1'b0), .fifo_prog_full (1'b0), .fifo_wfull (1'b0),
    .tx_nrx (s_tx), .jesd_en (s_jesd), .fifo_rd_en (s_rd), .fifo_wr_en (s_wr),
    .busy (s_busy), .done (s_done), .err (s_err), .sample_cnt (s_cnt)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge mclk);
    #1;
  endtask

  // Expected burst outcome from the burst rules: samples moved, error flag
  // and number of cycles jesd_en stays high.
  function automatic exp_t model(input logic dir, input int avail, input int pf, input int wf);
    exp_t e;
    e.dir = dir; e.n = L; e.err = 1'b0; e.n_act = L; e.start = 0;
    if (dir) begin
      if (avail < L) begin
        e.n = avail; e.err = 1'b1; e.n_act = avail + 1;
      end
    end else begin
      for (int k = 0; k < L; k++) begin
        if (k >= wf) begin
          e.n = k; e.err = 1'b1; e.n_act = k + 1;
          break;
        end
        if (k >= pf && k != L - 1) begin
          e.n = k; e.n_act = k + 1;
          break;
        end
      end
    end
    return e;
  endfunction

  // FIFO environment: apply the pops/pushes the DUT made in the previous cycle
  initial begin
    logic rd_s, wr_s;
    forever begin
      @(negedge mclk);
      rd_s = fifo_rd_en;
      wr_s = fifo_wr_en;
      @(posedge mclk);
      #1;
      if (rd_s && tx_avail > 0) tx_avail--;
      if (wr_s) rx_written++;
    end
  end

  // Monitor: follow each burst and compare against the queued expectation
  initial begin
    exp_t cur;
    logic in_burst = 1'b0;
    logic busy_q = 1'b0, jesd_q = 1'b0, tx_q = 1'b0;
    int   rd_cnt = 0, wr_cnt = 0, act_cnt = 0, dir_bad = 0;
    int   jesd_fall = -1, tx_fall = -1;
    forever begin
      @(negedge mclk);
      if (!rstn) begin
        in_burst = 1'b0; busy_q = 1'b0; jesd_q = 1'b0; tx_q = 1'b0;
        continue;
      end
      if (busy && !busy_q) begin
        if (sb_q.size() == 0) begin
          check("spurious_start", 1, 0);
        end else begin
          cur = sb_q[0];
          in_burst = 1'b1;
          rd_cnt = 0; wr_cnt = 0; act_cnt = 0; dir_bad = 0;
          jesd_fall = -1; tx_fall = -1;
          check("busy_latency", cyc, cur.start + 1);
          check("tx_nrx_at_start", int'(tx_nrx), int'(cur.dir));
          check("err_cleared", int'(err), 0);
          check("cnt_cleared", int'(sample_cnt), 0);
        end
      end
      if (in_burst) begin
        rd_cnt  += int'(fifo_rd_en);
        wr_cnt  += int'(fifo_wr_en);
        act_cnt += int'(jesd_en);
        if (jesd_en && tx_nrx != cur.dir) dir_bad++;
        if (jesd_en && !jesd_q) check("jesd_en_latency", cyc, cur.start + 1 + SETUP);
        if (!jesd_en && jesd_q) jesd_fall = cyc;
        if (!tx_nrx && tx_q) tx_fall = cyc;
      end
      if (done) begin
        if (!in_burst || sb_q.size() == 0) begin
          check("spurious_done", 1, 0);
        end else begin
          cur = sb_q.pop_front();
          in_burst = 1'b0;
          $display("burst dir=%0d start=%0d done=%0d cnt=%0d err=%0d rd=%0d wr=%0d",
                   cur.dir, cur.start, cyc, sample_cnt, err, rd_cnt, wr_cnt);
          check("done_cycle", cyc, cur.start + 1 + SETUP + cur.n_act + HOLD + GUARD);
          check("sample_cnt", int'(sample_cnt), cur.n);
          check("err", int'(err), int'(cur.err));
          check("rd_pulses", rd_cnt, cur.dir ? cur.n : 0);
          check("wr_pulses", wr_cnt, cur.dir ? 0 : cur.n);
          check("active_cycles", act_cnt, cur.n_act);
          check("tx_nrx_fall", tx_fall, cur.dir ? jesd_fall + HOLD : -1);
          check("dir_during_active", dir_bad, 0);
          check("busy_at_done", int'(busy), 0);
        end
      end
      busy_q = busy; jesd_q = jesd_en; tx_q = tx_nrx;
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_tx_nrx"}, int'(tx_nrx), 0);
    check({tag, "_jesd_en"}, int'(jesd_en), 0);
    check({tag, "_rd_en"}, int'(fifo_rd_en), 0);
    check({tag, "_wr_en"}, int'(fifo_wr_en), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_err"}, int'(err), 0);
    check({tag, "_sample_cnt"}, int'(sample_cnt), 0);
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy && k < 1000) begin
      tick();
      k++;
    end
    check("burst_terminates", int'(busy), 0);
  endtask

  task automatic run_burst(input logic dir, input int avail, input int pf, input int wf,
                           input int hold, input logic retrig);
    exp_t e;
    int   c;
    tx_avail = avail; rx_written = 0; pf_at = pf; wf_at = wf;
    btn_tx_nrx = dir;
    tick();
    c = cyc;
    proc_start = 1'b1;
    e = model(dir, avail, pf, wf);
    e.start = c;
    sb_q.push_back(e);
    for (int i = 0; i < hold; i++) tick();
    proc_start = 1'b0;
    btn_tx_nrx = ~dir;
    if (retrig) begin
      while (cyc < c + 10) tick();
      proc_start = 1'b1;
      tick();
      tick();
      proc_start = 1'b0;
    end
    wait_idle();
    tick();
    tick();
  endtask

  // Stimulus
  initial begin
    int c, s_rd_cnt, s_done_cyc, s_jesd_cyc;
    rstn = 1'b0; proc_start = 1'b0; btn_tx_nrx = 1'b0; s_start = 1'b0;
    tick();
    tick();
    check_all_zero("reset");
    rstn = 1'b1;
    tick();

    // Single-sample burst, no guard: done at start + 1 + 4 + 1 + 4
    c = cyc; s_start = 1'b1;
    s_rd_cnt = 0; s_done_cyc = -1; s_jesd_cyc = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge mclk);
      s_rd_cnt += int'(s_rd);
      if (s_done && s_done_cyc < 0) s_done_cyc = cyc;
      if (s_jesd && s_jesd_cyc < 0) s_jesd_cyc = cyc;
      tick();
      s_start = 1'b0;
    end
    check("small_done_cycle", s_done_cyc, c + 10);
    check("small_jesd_cycle", s_jesd_cyc, c + 5);
    check("small_rd_pulses", s_rd_cnt, 1);
    check("small_sample_cnt", int'(s_cnt), 1);
    check("small_err", int'(s_err), 0);
    check("small_busy", int'(s_busy), 0);

    // Directed bursts
    run_burst(1'b1, 100, NEVER, NEVER, 1, 1'b0);   // TX nominal
    run_burst(1'b1, 20, NEVER, NEVER, 1, 1'b0);    // TX underrun after 20
    run_burst(1'b0, 0, 30, NEVER, 1, 1'b0);        // RX prog_full after 30
    run_burst(1'b0, 0, NEVER, 30, 1, 1'b0);        // RX overflow after 30
    run_burst(1'b0, 0, L - 1, NEVER, 1, 1'b0);     // prog_full on last sample
    run_burst(1'b0, 0, 40, 40, 1, 1'b0);           // prog_full with wfull
    run_burst(1'b1, 0, NEVER, NEVER, 1, 1'b0);     // TX empty from the start
    run_burst(1'b1, L, NEVER, NEVER, 1, 1'b0);     // exactly one burst of data
    run_burst(1'b1, 100, NEVER, NEVER, 7, 1'b1);   // long start plus re-trigger
    run_burst(1'b0, 0, NEVER, NEVER, 2, 1'b1);     // RX full burst

    // Randomized bursts
    for (int i = 0; i < 12; i++) begin
      logic d;
      int   av, pf, wf;
      d  = 1'($urandom_range(0, 1));
      av = int'($urandom_range(0, 90));
      pf = ($urandom_range(0, 2) == 0) ? NEVER : int'($urandom_range(0, 80));
      wf = ($urandom_range(0, 2) == 0) ? NEVER : int'($urandom_range(0, 80));
      run_burst(d, av, pf, wf, int'($urandom_range(1, 8)), 1'($urandom_range(0, 1)));
    end

    // Reset in the middle of ACTIVE
    tx_avail = 200; btn_tx_nrx = 1'b1;
    tick();
    c = cyc;
    proc_start = 1'b1;
    sb_q.push_back(model(1'b1, 200, NEVER, NEVER));
    sb_q[sb_q.size() - 1].start = c;
    tick();
    proc_start = 1'b0;
    while (cyc < c + 20) tick();
    check("pre_reset_active", int'(jesd_en), 1);
    #2;
    rstn = 1'b0;
    #1;
    check_all_zero("midreset");
    sb_q.delete();
    tick();
    tick();
    rstn = 1'b1;
    tick();
    tick();
    run_burst(1'b1, 100, NEVER, NEVER, 1, 1'b0);   // nominal again after reset

    repeat (20) tick();
    check("scoreboard_drained", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound
  initial begin
    #600000;
    failures++;
    $display("FAIL watchdog: got timeout, want completion (cycle %0d)", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/jesd207_burst_ctrl.md
# jesd207_burst_ctrl

Burst sequencer for the JESD207 FIFO datapath in the `mclk` domain. It turns a `proc_start` request into one correctly ordered interface burst. It latches the direction from `btn_tx_nrx`, drives `tx_nrx` ahead of `jesd_en`, and meters FIFO reads (TX) or writes (RX) per sample. It ends the burst on count or on a FIFO boundary and reports the result. It sits between the control/UART logic and the `top_JESD207_FIFO` datapath.

## Interface
Parameters:
- `BURST_LEN`, 64: samples per burst; legal range 1..65535.
- `CNT_WID`, `$clog2(BURST_LEN+1)`: width of `sample_cnt`.
- `SETUP_CYC`, 4: cycles `tx_nrx` is stable before `jesd_en` rises; legal range 1..255.
- `HOLD_CYC`, 4: cycles `tx_nrx` is held after `jesd_en` falls; legal range 1..255.
- `GUARD_CYC`, 8: idle cycles before a new burst is accepted; legal range 0..255.

Ports:
- `mclk` in 1: sole clock, rising edge.
- `rstn` in 1: asynchronous, active-low reset.
- `proc_start` in 1: start request, level, synchronous to `mclk`. Only its rising edge acts.
- `btn_tx_nrx` in 1: requested direction, 1 = TX, 0 = RX. Sampled on the start edge.
- `fifo_rempty` in 1: datapath FIFO empty.
- `fifo_prog_full` in 1: datapath FIFO programmable-full.
- `fifo_wfull` in 1: datapath FIFO full.
- `tx_nrx` out 1: interface direction.
- `jesd_en` out 1: interface enable.
- `fifo_rd_en` out 1: TX sample pop.
- `fifo_wr_en` out 1: RX sample push.
- `busy` out 1: high whenever the state is not IDLE.
- `done` out 1: one-cycle pulse at the end of a burst.
- `err` out 1: sticky underrun/overflow flag. Cleared by the next accepted start.
- `sample_cnt` out `CNT_WID`: samples transferred in the current or last burst.

## Operation
- Reset values of all outputs are 0, and the state is IDLE.
- States are IDLE, SETUP, ACTIVE, HOLD and GUARD.
- IDLE → SETUP on a rising edge of `proc_start`, detected with a registered previous value.
  - Latch `btn_tx_nrx` into `tx_nrx`.
  - Clear `sample_cnt` and `err`.
- SETUP: count `SETUP_CYC` cycles, then go to ACTIVE with `jesd_en` = 1.
- ACTIVE, TX direction:
  - `fifo_rd_en` = `!fifo_rempty`, combinational from the state.
  - Each read increments `sample_cnt`.
  - `fifo_rempty` while `sample_cnt < BURST_LEN` sets `err` and ends the burst (underrun).
- ACTIVE, RX direction:
  - `fifo_wr_en` = `!fifo_wfull`; each write increments `sample_cnt`.
  - `fifo_prog_full` ends the burst cleanly and leaves `err` at 0.
  - `fifo_wfull` sets `err` and ends the burst (overflow).
- End on count: the transfer that makes `sample_cnt` = `BURST_LEN` ends ACTIVE.
- HOLD: `jesd_en` = 0, `tx_nrx` unchanged, for `HOLD_CYC` cycles.
- GUARD: `tx_nrx` = 0 for `GUARD_CYC` cycles. Then → IDLE with `done` = 1 for one cycle. With `GUARD_CYC` = 0, HOLD goes straight to IDLE with `done`.
- A `proc_start` edge while `busy` is ignored, not queued.
- `btn_tx_nrx` changes outside the start edge have no effect.
- `sample_cnt` saturates at `BURST_LEN` and holds its value in IDLE.

## Timing
- Edge at cycle 0 (registered):
  - `tx_nrx` and `busy` high at cycle 1.
  - `jesd_en` high at cycle 1+`SETUP_CYC`.
- First `fifo_rd_en`/`fifo_wr_en` occurs in the same cycle `jesd_en` rises. A full burst lasts exactly `BURST_LEN` cycles when not throttled.
- Terminating conditions (`fifo_rempty`, `fifo_prog_full`, `fifo_wfull`) are sampled each ACTIVE cycle. On such a cycle the rd/wr enables are already 0. `jesd_en` falls on the next edge.
- Simultaneous events:
  - Count reached and `fifo_prog_full` in the same cycle: count wins, `err` = 0.
  - `fifo_wfull` in the same cycle as `fifo_prog_full`: `err` = 1.
- Reset mid-burst: `jesd_en`, `tx_nrx` and the FIFO enables go low asynchronously, with no HOLD and no `done`.
- `done` is asserted at cycle 1+`SETUP_CYC`+N+`HOLD_CYC`+`GUARD_CYC`, where N is the number of ACTIVE cycles.

## Structure
- Shared package `jesd207_pkg`:
  - state enum `burst_state_t`
  - direction constants `DIR_TX` = 1 and `DIR_RX` = 0
  - default parameter constants
- One natural sub-module, `jesd207_phase_timer`: a loadable down-counter with a `zero` flag, reused by SETUP, HOLD and GUARD.
- Edge detect, FSM and sample counter live in the top module.

## Test plan
- TX nominal: FIFO holds ≥64 samples, start with `btn_tx_nrx` = 1.
  - `tx_nrx` rises at cycle 1 and `jesd_en` at cycle 5.
  - 64 `fifo_rd_en` pulses, then `jesd_en` falls and `tx_nrx` falls 4 cycles later.
  - `done` at cycle 81, `err` = 0, `sample_cnt` = 64.
- TX underrun: 20 samples queued → 20 reads, `err` = 1, `sample_cnt` = 20, HOLD and GUARD still executed.
- RX `fifo_prog_full` asserted after 30 writes → burst ends, `sample_cnt` = 30, `err` = 0. RX `fifo_wfull` asserted instead → `err` = 1.
- `proc_start` held high for 7 cycles, plus a second edge during ACTIVE → exactly one burst, one `done`.
- `rstn` low during ACTIVE:
  - All outputs are 0 within the reset assertion, with no `done`.
  - A new start after release behaves as in the TX nominal case.
- `GUARD_CYC` = 0 and `BURST_LEN` = 1: a single transfer occurs, `done` at cycle 1+4+1+4 = 10.
